// File: rtl/line_burst_bridge.sv
// line_burst_bridge: splits 256-bit cache-line transfers into 32-bit memory
// beats (ascending order, beat 0 = least-significant word) and reassembles
// fill beats into a full line. One line transaction in flight at a time.
module line_burst_bridge #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              MEM_CLK,
    input  logic              rst_n,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [ADDR_W-1:0] line_address,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    output logic [3:0]        pmem_byte_enable,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int BEAT_SH  = $clog2(BEAT_W / 8);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_BEAT = 2'd1;
    localparam logic [1:0] S_WR_BEAT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_rdata;

    logic [ADDR_W-1:0] w_line_base;
    logic [ADDR_W-1:0] w_beat_offset;
    logic              w_beat_done;

    assign w_line_base   = line_address & BASE_MASK;
    assign w_beat_offset = ADDR_W'(r_cnt) << BEAT_SH;
    assign w_beat_done   = pmem_resp && (r_state == S_RD_BEAT || r_state == S_WR_BEAT);

    // Transaction sequencing: request capture, beat counting, completion
    always_ff @(posedge MEM_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (line_write) begin
                        r_base  <= w_line_base;
                        r_wdata <= line_wdata;
                        r_cnt   <= '0;
                        r_state <= S_WR_BEAT;
                    end else if (line_read) begin
                        r_base  <= w_line_base;
                        r_cnt   <= '0;
                        r_state <= S_RD_BEAT;
                    end
                end
                S_RD_BEAT, S_WR_BEAT: begin
                    if (w_beat_done) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BEAT) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Fill line assembly: each accepted read beat lands in its word slot
    always_ff @(posedge MEM_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (pmem_resp && r_state == S_RD_BEAT) begin
            r_rdata[r_cnt*BEAT_W +: BEAT_W] <= pmem_rdata;
        end
    end

    // Beat-side outputs decoded from registered state only
    always_comb begin
        pmem_read        = (r_state == S_RD_BEAT);
        pmem_write       = (r_state == S_WR_BEAT);
        pmem_address     = r_base + w_beat_offset;
        pmem_wdata       = '0;
        pmem_byte_enable = 4'h0;
        if (r_state == S_WR_BEAT) begin
            pmem_wdata       = r_wdata[r_cnt*BEAT_W +: BEAT_W];
            pmem_byte_enable = 4'hF;
        end
    end

    assign line_resp  = (r_state == S_DONE);
    assign line_rdata = r_rdata;

endmodule

// File: doc/line_burst_bridge.md
# line_burst_bridge

Serializes 256-bit cache-line transfers into 32-bit physical-memory beats and reassembles read beats into a full line. It sits directly downstream of the `cache` block: the cache's line-side bus connects to it, and its beat-side bus connects to the 32-bit physical memory model. It handles one line transaction at a time, with a per-beat request/response handshake toward memory.

## Interface
- `LINE_W`, 256, cache-line width in bits
- `BEAT_W`, 32, memory beat width in bits; `LINE_W/BEAT_W` (8) beats per line
- `ADDR_W`, 32, byte-address width
- `MEM_CLK`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `line_read`  in  1  cache requests a line fill
- `line_write`  in  1  cache requests a line write-back
- `line_address`  in  ADDR_W  line byte address; low 5 bits ignored (forced 0)
- `line_wdata`  in  LINE_W  line to write back
- `line_rdata`  out  LINE_W  assembled fill line
- `line_resp`  out  1  one-cycle completion pulse
- `pmem_read`  out  1  beat read strobe
- `pmem_write`  out  1  beat write strobe
- `pmem_address`  out  ADDR_W  beat byte address = base + 4*beat
- `pmem_wdata`  out  BEAT_W  beat write data
- `pmem_byte_enable`  out  4  `4'hF` during writes, `4'h0` otherwise
- `pmem_rdata`  in  BEAT_W  beat read data, valid with `pmem_resp`
- `pmem_resp`  in  1  memory accepted/completed the current beat

## Operation
- FSM states: IDLE, RD_BEAT, WR_BEAT, DONE. A 3-bit beat counter runs 0..7.
- IDLE: on `line_write`, latch base = {`line_address[31:5]`, 5'b0} and `line_wdata`, clear the counter, and go to WR_BEAT. Otherwise, on `line_read`, latch the base, clear the counter, and go to RD_BEAT. If both are high, the write wins.
- RD_BEAT: `pmem_read`=1 and `pmem_address`=base+4*cnt.
  - On a sampled `pmem_resp`, store `pmem_rdata` into `line_rdata[32*cnt +: 32]` and increment cnt.
  - If cnt==7, go to DONE instead.
- WR_BEAT: `pmem_write`=1, `pmem_wdata`=`line_wdata_latched[32*cnt +: 32]`, and `pmem_byte_enable`=4'hF. Advance on `pmem_resp` the same way as RD_BEAT.
- Beat order is ascending: beat 0 is the least-significant word. The counter wraps 7->0 on leaving the beat state.
- DONE: `line_resp`=1 for exactly one cycle, then go to IDLE. The request inputs are ignored in DONE. The cache drops its request in the cycle after `line_resp`.
- `line_rdata` holds the last fill until the first beat of the next read overwrites it. Write-backs never modify it.
- `pmem_resp` sampled in IDLE or DONE is ignored. Request changes after latching are ignored until DONE.
- Reset (asynchronous, any state):
  - State goes to IDLE and cnt to 0.
  - All outputs go to 0, including `line_rdata`, `pmem_address` and `pmem_wdata`.
  - An in-flight transfer is abandoned with no `line_resp`.

## Timing
- The `pmem_*` strobes, address and data are registered state decodes, stable for the whole beat until `pmem_resp` is sampled.
- Between consecutive beats, the strobe stays high and the address and data change on the edge that samples `pmem_resp`.
- Let edge 0 be the one that samples a request in IDLE. With a zero-wait memory (`pmem_resp` high every cycle):
  - beats occupy cycles 1-8;
  - `line_resp` is high in cycle 9;
  - IDLE resumes in cycle 10.
- With W wait cycles per beat, `line_resp` arrives in cycle 8*(W+1)+1.
- A new request can be accepted at the earliest in cycle 10, so the minimum spacing between line responses is 10 cycles.
- After `rst_n` deasserts, the first request can be sampled on the next rising edge.

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0 for 5 cycles with random inputs.
  - Required: every output is 0 and no strobes are asserted. Release, then stay idle for 3 cycles with `pmem_resp` pulsed: no strobe, no `line_resp`.
- Fill, zero-wait:
  - Stimulus: `line_read` at address 0x0000_1234; memory returns 0x1000_0000+i for beat i.
  - Required: `pmem_address` runs 0x1220..0x123C; `line_resp` in cycle 9; `line_rdata` = {0x10000007,…,0x10000000}.
- Fill, 3 wait cycles per beat:
  - Stimulus: same fill, memory delays each `pmem_resp` by 3 cycles.
  - Required: `line_resp` in cycle 33; `line_rdata` identical to the zero-wait case.
- Write-back:
  - Stimulus: `line_write` with address 0x0000_4321 and `line_wdata` = 0xAABBCCDD repeated with word index i in the top byte (word i = {i[7:0], 0xBBCCDD}).
  - Required: 8 writes to 0x4320..0x433C with `pmem_byte_enable`=0xF; `line_rdata` unchanged.
- Simultaneous request:
  - Stimulus: `line_read` and `line_write` both high in IDLE.
  - Required: only `pmem_write` beats occur; exactly one `line_resp`.
- Reset mid-burst:
  - Stimulus: assert `rst_n`=0 after beat 3 of a fill.
  - Required: strobes drop immediately with no `line_resp`. A subsequent fill of 0x0000_0000 then completes normally with correct data.
